ysyx_22040365_mc_core: RTL

- Parametrised multi-cycle successor to the single-cycle addi/ebreak top.
- Fetches instructions over a valid/request handshake instead of a free-running `inst` input.
- Executes a small integer subset (addi, add, sub, lui, ebreak) through a fetch/execute/writeback FSM, with a configurable register-file size and datapath width.
- Reports halt and illegal-instruction status as ports, which replace the DPI quit call; the testbench owns simulation exit.

---
 rtl/ysyx_22040365_mc_core.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ysyx_22040365_mc_core.sv
// Multi-cycle RV integer core: fetch/execute/writeback FSM over a valid/request
// instruction port, supporting addi, add, sub, lui and ebreak.
module ysyx_22040365_mc_core #(
  parameter int          XLEN     = 64,
  parameter int          NREG     = 32,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_valid,
  input  logic [31:0]     inst,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            halt,
  output logic            illegal,
  output logic [XLEN-1:0] a0,
  output logic [1:0]      dbg_state_o
);

  localparam int AW = $clog2(NREG);
  localparam logic [XLEN-1:0] RST_PC = RESET_PC[XLEN-1:0];

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_e;

  // Handshake: inst is consumed on any rising edge where inst_req && inst_valid
  // are both high; inst_valid while inst_req is low has no effect.
  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   rf_q [NREG];
  logic              rf_we;

  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [4:0]        rd, rs1, rs2;
  logic [63:0]       imm_i64, imm_u64;
  logic [XLEN-1:0]   imm_i, imm_u, rs1_val, rs2_val, result;
  logic              rd_ok, rs1_ok, rs2_ok;
  logic              is_addi, is_add, is_sub, is_lui, is_ebreak, legal;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign funct7  = ir_q[31:25];
  assign imm_i64 = {{52{ir_q[31]}}, ir_q[31:20]};
  assign imm_u64 = {{32{ir_q[31]}}, ir_q[31:12], 12'b0};
  assign imm_i   = imm_i64[XLEN-1:0];
  assign imm_u   = imm_u64[XLEN-1:0];

  // Register fields beyond NREG (RV-E) make an otherwise valid encoding illegal.
  assign rd_ok  = int'(rd)  < NREG;
  assign rs1_ok = int'(rs1) < NREG;
  assign rs2_ok = int'(rs2) < NREG;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && rs1_ok) rs1_val = rf_q[rs1[AW-1:0]];
    if (rs2 != 5'd0 && rs2_ok) rs2_val = rf_q[rs2[AW-1:0]];
  end

  assign is_ebreak = (ir_q == 32'h0010_0073);
  assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_lui    = (opcode == 7'b0110111);
  assign legal     = (is_addi && rd_ok && rs1_ok)
                   || ((is_add || is_sub) && rd_ok && rs1_ok && rs2_ok)
                   || (is_lui && rd_ok);

  always_comb begin
    result = '0;
    if (is_addi)     result = rs1_val + imm_i;
    else if (is_add) result = rs1_val + rs2_val;
    else if (is_sub) result = rs1_val - rs2_val;
    else if (is_lui) result = imm_u;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    res_d     = res_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    inst_req  = 1'b0;
    wb_valid  = 1'b0;
    wb_addr   = 5'd0;
    wb_data   = '0;
    case (state_q)
      S_FETCH: begin
        inst_req = 1'b1;
        if (inst_valid) begin
          ir_d    = inst;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d = result;
        if (is_ebreak) begin
          state_d = S_HALT;
        end else if (legal) begin
          state_d = S_WB;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_WB: begin
        wb_valid = 1'b1;
        wb_addr  = rd;
        wb_data  = res_q;
        rf_we    = (rd != 5'd0);
        pc_d     = pc_q + XLEN'(4);
        state_d  = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RST_PC;
      ir_q      <= '0;
      res_q     <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      res_q     <= res_d;
      illegal_q <= illegal_d;
      if (rf_we) rf_q[rd[AW-1:0]] <= res_q;
    end
  end

  assign inst_addr   = pc_q;
  assign halt        = (state_q == S_HALT);
  assign illegal     = illegal_q;
  assign a0          = rf_q[10];
  assign dbg_state_o = state_q;

endmodule
